// File: rtl/xbar_alloc_pkg.sv
// Shared NoC definitions for the crossbar allocator: port indices, flit
// type codes, per-output allocator state encoding and the idle select code.
package noc_pkg;

    localparam int NPORTS = 5;

    localparam int PORT_L = 0;
    localparam int PORT_N = 1;
    localparam int PORT_E = 2;
    localparam int PORT_W = 3;
    localparam int PORT_S = 4;

    localparam logic [2:0] FLIT_HEAD   = 3'b001;
    localparam logic [2:0] FLIT_BODY   = 3'b010;
    localparam logic [2:0] FLIT_TAIL   = 3'b100;
    localparam logic [2:0] FLIT_SINGLE = 3'b101;

    localparam logic [2:0] NO_SEL = 3'b111;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } alloc_state_e;

    // A flit that may open a packet on an idle output.
    function automatic logic flit_is_start(input logic [2:0] f);
        return (f == FLIT_HEAD) || (f == FLIT_SINGLE);
    endfunction

    // A flit that continues a packet on a locked output.
    function automatic logic flit_is_cont(input logic [2:0] f);
        return (f == FLIT_BODY) || (f == FLIT_TAIL);
    endfunction

    function automatic logic [2:0] next_port(input logic [2:0] p);
        return (p >= 3'(NPORTS - 1)) ? 3'd0 : p + 3'd1;
    endfunction

endpackage

// File: rtl/xbar_alloc_if.sv
// Crossbar allocator bus: per-input requests in, per-input grants and
// per-output select/valid out.
interface xbar_alloc_if;
    import noc_pkg::*;

    logic [NPORTS-1:0]   req;
    logic [5*NPORTS-1:0] dest;
    logic [3*NPORTS-1:0] flit_id;
    logic [NPORTS-1:0]   credit_ret;
    logic [NPORTS-1:0]   gnt;
    logic [3*NPORTS-1:0] xbar_sel;
    logic [NPORTS-1:0]   out_valid;
    logic                credit_err;

    modport master (
        output req, dest, flit_id, credit_ret,
        input  gnt, xbar_sel, out_valid, credit_err
    );

    modport slave (
        input  req, dest, flit_id, credit_ret,
        output gnt, xbar_sel, out_valid, credit_err
    );

endinterface

// File: rtl/xbar_alloc_out_alloc.sv
// One output's allocator: round-robin packet arbitration with wormhole lock,
// downstream credit tracking and a lock-stall timeout.
module out_alloc
    import noc_pkg::*;
#(
    parameter int CREDIT_DEPTH = 4,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NPORTS-1:0]   req,
    input  logic [NPORTS-1:0]   dest_hit,
    input  logic [3*NPORTS-1:0] flit_id,
    input  logic                credit_ret,
    output logic [NPORTS-1:0]   gnt,
    output logic [2:0]          sel,
    output logic                valid,
    output logic                credit_over
);

    localparam int TO_W = (LOCK_TIMEOUT < 2) ? 1 : $clog2(LOCK_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);
    localparam logic [3:0] CRED_MAX = 4'(CREDIT_DEPTH);

    alloc_state_e    state, state_n;
    logic [2:0]      owner, owner_n;
    logic [2:0]      rr, rr_n;
    logic [3:0]      credit, credit_n;
    logic [TO_W-1:0] tmo, tmo_n;

    logic [NPORTS-1:0] cand;
    logic [2:0]        pick;
    logic              found;
    logic              owner_ok;
    logic [2:0]        src;
    logic [2:0]        src_flit;
    logic              xfer;

    // Round-robin search over packet-opening requests, starting at rr.
    always_comb begin
        int idx;
        cand  = '0;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NPORTS; i++) begin
            cand[i] = req[i] & dest_hit[i] & flit_is_start(flit_id[3*i +: 3]);
        end
        for (int k = 0; k < NPORTS; k++) begin
            idx = int'(rr) + k;
            if (idx >= NPORTS) idx = idx - NPORTS;
            if (!found && cand[idx]) begin
                found = 1'b1;
                pick  = 3'(idx);
            end
        end
    end

    always_comb begin
        owner_ok = req[owner] & dest_hit[owner]
                 & flit_is_cont(flit_id[3*int'(owner) +: 3]);
        if (state == ST_IDLE) begin
            src  = pick;
            xfer = found && (credit != 4'd0);
        end else begin
            src  = owner;
            xfer = owner_ok && (credit != 4'd0);
        end
        if (rst) xfer = 1'b0;
        src_flit = flit_id[3*int'(src) +: 3];

        gnt = '0;
        if (xfer) gnt[src] = 1'b1;
        sel         = xfer ? src : NO_SEL;
        valid       = xfer;
        credit_over = !rst && credit_ret && !xfer && (credit == CRED_MAX);
    end

    always_comb begin
        state_n  = state;
        owner_n  = owner;
        rr_n     = rr;
        credit_n = credit;
        tmo_n    = tmo;

        if (xfer && !credit_ret) begin
            credit_n = credit - 4'd1;
        end else if (!xfer && credit_ret && (credit != CRED_MAX)) begin
            credit_n = credit + 4'd1;
        end

        case (state)
            ST_IDLE: begin
                if (xfer) begin
                    if (src_flit == FLIT_HEAD) begin
                        state_n = ST_LOCKED;
                        owner_n = src;
                        tmo_n   = '0;
                    end else begin
                        rr_n = next_port(src);
                    end
                end
            end
            ST_LOCKED: begin
                if (xfer) begin
                    tmo_n = '0;
                    if (src_flit == FLIT_TAIL) begin
                        state_n = ST_IDLE;
                        rr_n    = next_port(owner);
                    end
                end else if (LOCK_TIMEOUT != 0) begin
                    // A stalled owner loses the output so others are not starved.
                    if (tmo == TO_LAST) begin
                        state_n = ST_IDLE;
                        rr_n    = next_port(owner);
                        tmo_n   = '0;
                    end else begin
                        tmo_n = tmo + TO_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            owner  <= '0;
            rr     <= '0;
            credit <= CRED_MAX;
            tmo    <= '0;
        end else begin
            state  <= state_n;
            owner  <= owner_n;
            rr     <= rr_n;
            credit <= credit_n;
            tmo    <= tmo_n;
        end
    end

endmodule

// File: rtl/xbar_alloc.sv
// 5x5 crossbar allocator: one out_alloc per output; per-input grants are the
// OR of the per-output grants, and credit overflow is latched as sticky.
module xbar_alloc
    import noc_pkg::*;
#(
    parameter int CREDIT_DEPTH = 4,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    xbar_alloc_if.slave  bus
);

    logic [NPORTS-1:0] hit     [NPORTS];
    logic [NPORTS-1:0] gnt_out [NPORTS];
    logic [2:0]        sel_out [NPORTS];
    logic [NPORTS-1:0] valid_out;
    logic [NPORTS-1:0] over;
    logic              credit_err_q;

    // Transpose the per-input one-hot destinations into per-output hit vectors.
    always_comb begin
        for (int o = 0; o < NPORTS; o++) begin
            for (int i = 0; i < NPORTS; i++) begin
                hit[o][i] = bus.dest[NPORTS*i + o];
            end
        end
    end

    for (genvar o = 0; o < NPORTS; o++) begin : g_out
        out_alloc #(
            .CREDIT_DEPTH (CREDIT_DEPTH),
            .LOCK_TIMEOUT (LOCK_TIMEOUT)
        ) u_out_alloc (
            .clk         (clk),
            .rst         (rst),
            .req         (bus.req),
            .dest_hit    (hit[o]),
            .flit_id     (bus.flit_id),
            .credit_ret  (bus.credit_ret[o]),
            .gnt         (gnt_out[o]),
            .sel         (sel_out[o]),
            .valid       (valid_out[o]),
            .credit_over (over[o])
        );
    end

    always_comb begin
        logic [NPORTS-1:0] g;
        g = '0;
        for (int o = 0; o < NPORTS; o++) begin
            g = g | gnt_out[o];
            bus.xbar_sel[3*o +: 3] = sel_out[o];
        end
        bus.gnt       = g;
        bus.out_valid = valid_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_err_q <= 1'b0;
        end else if (|over) begin
            credit_err_q <= 1'b1;
        end
    end

    assign bus.credit_err = credit_err_q;

endmodule

// File: doc/xbar_alloc.md
XBAR_ALLOC -- requirements
Module: xbar_alloc

Interface
REQ-001 SHALL have parameter CREDIT_DEPTH, default 4: downstream buffer slots per output; range 1..15.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 64: idle cycles before a locked output is force-released; 0 disables the timeout.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port req, input, 5: per-input flit valid, port order index 0..4 = L,N,E,W,S.
REQ-006 SHALL have port dest, input, 25: per-input one-hot destination output, 5 bits per input, input i at bits [5i+4:5i].
REQ-007 SHALL have port flit_id, input, 15: per-input 3-bit flit type at bits [3i+2:3i]; 3'b001 header, 3'b010 body, 3'b100 tail, 3'b101 single-flit packet.
REQ-008 SHALL have port credit_ret, input, 5: per-output one-cycle pulse returning one downstream slot.
REQ-009 SHALL have port gnt, output, 5: per-input grant; flit i transfers in any cycle where req[i] and gnt[i] are both high.
REQ-010 SHALL have port xbar_sel, output, 15: per-output 3-bit source input index; 3'b111 when no transfer.
REQ-011 SHALL have port out_valid, output, 5: per-output flag, high in a cycle a flit crosses that output.
REQ-012 SHALL have port credit_err, output, 1: sticky flag, set by a credit return while the counter is already at CREDIT_DEPTH.

Function
REQ-013 SHALL keep per-output state: FSM {IDLE, LOCKED}, 3-bit owner, 3-bit round-robin pointer, 4-bit credit counter, timeout counter.
REQ-014 SHALL compute gnt, xbar_sel and out_valid combinationally from registered state and current inputs (zero-latency grant).
REQ-015 IDLE: SHALL select, among inputs with req, header or single flit, and dest on this output, the first at or after the RR pointer, wrapping 4->0.
REQ-016 SHALL grant that selection only if credit > 0; with credit == 0, no grant and no state change.
REQ-017 IDLE grant of a header: next state LOCKED, owner = selected input.
REQ-018 IDLE grant of a single flit: state stays IDLE, RR pointer = selected+1 mod 5.
REQ-019 LOCKED: SHALL grant only the owner, and only when it has req, dest on this output, body or tail flit, and credit > 0; other inputs wait.
REQ-020 LOCKED tail transfer: next state IDLE, RR pointer = owner+1 mod 5.
REQ-021 SHALL ignore body or tail flits arriving at an IDLE output: no grant, no state change.
REQ-022 SHALL ignore headers from the owner while LOCKED.
REQ-023 Credit counter: -1 per transfer, +1 per credit_ret; both in one cycle leaves it unchanged.
REQ-024 Credit counter SHALL saturate at CREDIT_DEPTH; a credit_ret at CREDIT_DEPTH with no same-cycle transfer sets credit_err.
REQ-025 gnt[i] SHALL be the OR over outputs of that output granting input i; one-hot dest guarantees at most one output per input.
REQ-026 Timeout counter: counts LOCKED cycles with no transfer, clears on any transfer.
REQ-027 When the timeout counter reaches LOCK_TIMEOUT, SHALL force the output to IDLE with RR pointer = owner+1.
REQ-028 If a transfer occurs in the same cycle the timeout counter reaches LOCK_TIMEOUT, the transfer wins and the counter clears.

Reset
REQ-029 While rst is high, SHALL drive gnt=0, out_valid=0, xbar_sel=all 3'b111.
REQ-030 On rst, all FSMs SHALL go to IDLE, RR pointers and owners to 0, credit counters to CREDIT_DEPTH, timeout counters to 0, credit_err to 0.
REQ-031 rst mid-packet SHALL drop all locks with no tail required.

Structure
REQ-032 Shared package noc_pkg SHALL hold: NPORTS=5, port indices L/N/E/W/S, flit_id constants, the IDLE/LOCKED state encoding, and NO_SEL=3'b111.
REQ-033 SHALL use one sub-module, out_alloc (per-output FSM, RR pick, credit and timeout logic), instantiated 5 times; the top level ORs the grants.

Verification
REQ-034 L sends header/body/tail to E, credits 4 -> gnt[0] high 3 cycles, xbar_sel[E]=0, E credit ends at 1, E returns to IDLE.
REQ-035 N and W send headers to S in the same cycle after reset -> N is granted first; W is granted on the cycle after N's tail; pointer ends at 4.
REQ-036 E credit 0, L header to E -> gnt[0]=0; credit_ret[E] pulse -> grant on the next cycle.
REQ-037 Transfer and credit_ret on the same output in one cycle -> counter unchanged; credit_ret at 4 with no transfer -> credit_err=1, held until rst.
REQ-038 LOCK_TIMEOUT=8, owner stalls after header -> output IDLE after 8 idle cycles; a waiting header from another input is granted next.
REQ-039 rst asserted while 2 outputs are LOCKED -> next cycle all outputs IDLE, credits=CREDIT_DEPTH, gnt=0.
